// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// funct3 load/store encodings, FSM states and MMIO register offsets.
package dmem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_RESP
   } state_e;

   localparam int unsigned IO_LED = 0;
   localparam int unsigned IO_CNT = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/replicated data and
// load lane extraction with sign/zero extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  byte_en,
   output logic [31:0] st_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      byte_en = '0;
      st_word = '0;
      case (funct3)
         F3_B: begin
            byte_en = 4'b0001 << addr_lo;
            st_word = {4{st_data[7:0]}};
         end
         F3_H: begin
            byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            st_word = {2{st_data[15:0]}};
         end
         F3_W: begin
            byte_en = 4'b1111;
            st_word = st_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = ld_word[7:0];
      case (addr_lo)
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         2'd3:    ld_byte = ld_word[31:24];
         default: ld_byte = ld_word[7:0];
      endcase
      ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
      case (funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'h0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'h0, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against a byte-enabled word RAM
// or the LED/cycle-counter MMIO window, answered with a d_ready/d_err pulse.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned       DEPTH   = 1024,
   parameter int unsigned       ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0001_0000),
   parameter int unsigned       LED_W   = 8
)(
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [31:0]       ddata_w,
   input  logic              d_rw,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   output logic [31:0]       ddata_r,
   output logic              d_ready,
   output logic              d_err,
   output logic [LED_W-1:0]  led
);

   localparam int unsigned       IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(DEPTH * 4);
   localparam logic [ADDR_W-1:0] LED_ADDR = IO_BASE + ADDR_W'(IO_LED);
   localparam logic [ADDR_W-1:0] CNT_ADDR = IO_BASE + ADDR_W'(IO_CNT);

   logic [31:0]      mem [DEPTH];
   logic [31:0]      ram_q;
   logic [31:0]      io_q;
   logic [31:0]      cnt;
   state_e           state;
   logic [2:0]       f3_q;
   logic [1:0]       lo_q;
   logic             io_sel_q;
   logic             in_ram, is_led, is_cnt, f3_ok, misal, err, st_go;
   logic [IDX_W-1:0] idx;
   logic [2:0]       al_f3;
   logic [1:0]       al_lo;
   logic [3:0]       byte_en;
   logic [31:0]      st_word, ld_word, ld_data;

   assign idx = daddr[IDX_W+1:2];

   always_comb begin
      in_ram = daddr < RAM_TOP;
      is_led = daddr == LED_ADDR;
      is_cnt = daddr == CNT_ADDR;
      f3_ok  = (funct3 == F3_B) | (funct3 == F3_H) | (funct3 == F3_W)
             | (funct3 == F3_BU) | (funct3 == F3_HU);
      misal  = (((funct3 == F3_H) | (funct3 == F3_HU)) & daddr[0])
             | ((funct3 == F3_W) & (daddr[1:0] != 2'b00));
      err    = (MemRead & MemWrite)
             | (MemRead & ~d_rw) | (MemWrite & d_rw)
             | ~f3_ok | (MemWrite & ((funct3 == F3_BU) | (funct3 == F3_HU)))
             | misal
             | ~(in_ram | is_led | is_cnt)
             | ((is_led | is_cnt) & (funct3 != F3_W))
             | (MemWrite & is_cnt);
      st_go  = RESET_N & (state == S_IDLE) & MemWrite & ~err & in_ram;
   end

   // One aligner serves both directions: stores only happen in IDLE, extraction only in RD.
   assign al_f3   = (state == S_RD) ? f3_q : funct3;
   assign al_lo   = (state == S_RD) ? lo_q : daddr[1:0];
   assign ld_word = io_sel_q ? io_q : ram_q;

   dmem_lane_align u_align (
      .funct3  (al_f3),
      .addr_lo (al_lo),
      .st_data (ddata_w),
      .ld_word (ld_word),
      .byte_en (byte_en),
      .st_word (st_word),
      .ld_data (ld_data)
   );

   always_ff @(posedge CLK) begin
      ram_q <= mem[idx];
      if (st_go) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[idx][8*i +: 8] <= st_word[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state    <= S_IDLE;
         ddata_r  <= '0;
         d_ready  <= 1'b0;
         d_err    <= 1'b0;
         led      <= '0;
         cnt      <= '0;
         f3_q     <= '0;
         lo_q     <= '0;
         io_sel_q <= 1'b0;
         io_q     <= '0;
      end else begin
         cnt     <= cnt + 32'd1;
         d_ready <= 1'b0;
         d_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (MemRead | MemWrite) begin
                  f3_q     <= funct3;
                  lo_q     <= daddr[1:0];
                  io_sel_q <= ~in_ram;
                  io_q     <= is_cnt ? cnt : 32'(led);
                  if (err) begin
                     state   <= S_RESP;
                     d_ready <= 1'b1;
                     d_err   <= 1'b1;
                     ddata_r <= '0;
                  end else if (MemWrite) begin
                     state   <= S_RESP;
                     d_ready <= 1'b1;
                     if (is_led) led <= ddata_w[LED_W-1:0];
                  end else begin
                     state <= S_RD;
                  end
               end
            end
            S_RD: begin
               ddata_r <= ld_data;
               d_ready <= 1'b1;
               state   <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed accesses push expected responses,
// a negedge monitor pops and checks data, error flag and latency on each d_ready.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int unsigned DEPTH   = 1024;
   localparam logic [31:0] IO_BASE = 32'h0001_0000;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] ddata_w = '0;
   logic        d_rw = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] ddata_r;
   logic        d_ready;
   logic        d_err;
   logic [7:0]  led;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        chk;
      logic        err;
      int          lat;
      int          t0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   dmem_responder #(
      .DEPTH   (DEPTH),
      .ADDR_W  (32),
      .IO_BASE (IO_BASE),
      .LED_W   (8)
   ) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .daddr    (daddr),
      .ddata_w  (ddata_w),
      .d_rw     (d_rw),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .funct3   (funct3),
      .ddata_r  (ddata_r),
      .d_ready  (d_ready),
      .d_err    (d_err),
      .led      (led)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (d_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_ready: d_ready=1 at cycle %0d with nothing outstanding", cyc);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_err"}, {31'b0, d_err}, {31'b0, mon_e.err});
            check({mon_e.name, "_lat"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            if (mon_e.chk) check({mon_e.name, "_data"}, ddata_r, mon_e.data);
         end
      end else if (d_err) begin
         vectors++;
         miscompares++;
         $display("FAIL err_without_ready: d_err=1, required 0 at cycle %0d", cyc);
      end
   end

   task automatic access(input string nm, input logic rd, input logic wr, input logic rw,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic chk, input logic exp_e,
                         input int lat, output logic [31:0] got, output int t0);
      exp_t e;
      bit   seen = 1'b0;
      @(negedge CLK);
      MemRead  = rd;
      MemWrite = wr;
      d_rw     = rw;
      funct3   = f3;
      daddr    = a;
      ddata_w  = wd;
      t0       = cyc;
      e.name = nm; e.data = exp_d; e.chk = chk; e.err = exp_e; e.lat = lat; e.t0 = cyc;
      sb.push_back(e);
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLK);
         seen = d_ready;
      end
      got      = ddata_r;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: no d_ready within 10 cycles, required latency %0d", nm, lat);
         if (sb.size() > 0) e = sb.pop_front();
      end
   endtask

   task automatic st(input string nm, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic exp_e);
      logic [31:0] g;
      int          t;
      access(nm, 1'b0, 1'b1, 1'b0, f3, a, wd, '0, exp_e, exp_e, 1, g, t);
   endtask

   task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] exp_d, input logic exp_e);
      logic [31:0] g;
      int          t;
      access(nm, 1'b1, 1'b0, 1'b1, f3, a, '0, exp_e ? 32'h0 : exp_d, 1'b1, exp_e,
             exp_e ? 1 : 2, g, t);
   endtask

   initial begin
      logic [31:0] c1, c2;
      int          t1, t2;
      exp_t        e;
      bit          seen;

      repeat (3) @(negedge CLK);
      check("rst_ddata_r", ddata_r, 32'h0);
      check("rst_ready", {31'b0, d_ready}, 32'h0);
      check("rst_led", {24'h0, led}, 32'h0);
      RESET_N = 1'b1;

      st("sw_10", F3_W, 32'h10, 32'hDEAD_BEEF, 1'b0);
      ld("lw_10", F3_W, 32'h10, 32'hDEAD_BEEF, 1'b0);

      st("sb_11", F3_B, 32'h11, 32'hCCCC_CC80, 1'b0);
      ld("lw_after_sb", F3_W, 32'h10, 32'hDEAD_80EF, 1'b0);
      ld("lb_11", F3_B, 32'h11, 32'hFFFF_FF80, 1'b0);
      ld("lbu_11", F3_BU, 32'h11, 32'h0000_0080, 1'b0);

      st("sh_12", F3_H, 32'h12, 32'hABCD_1234, 1'b0);
      ld("lh_12", F3_H, 32'h12, 32'h0000_1234, 1'b0);
      ld("lh_10", F3_H, 32'h10, 32'hFFFF_80EF, 1'b0);
      ld("lhu_10", F3_HU, 32'h10, 32'h0000_80EF, 1'b0);
      ld("lb_13", F3_B, 32'h13, 32'h0000_0012, 1'b0);
      ld("lh_13_misal", F3_H, 32'h13, 32'h0, 1'b1);
      ld("lw_after_sh", F3_W, 32'h10, 32'h1234_80EF, 1'b0);

      st("sw_0", F3_W, 32'h0, 32'h1111_1111, 1'b0);
      st("sw_unmapped", F3_W, DEPTH * 4, 32'hFFFF_FFFF, 1'b1);
      ld("lw_0_intact", F3_W, 32'h0, 32'h1111_1111, 1'b0);
      access("rd_and_wr", 1'b1, 1'b1, 1'b1, F3_W, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 1, c1, t1);
      ld("lw_10_intact", F3_W, 32'h10, 32'h1234_80EF, 1'b0);
      st("sw_top", F3_W, DEPTH * 4 - 4, 32'h0BAD_F00D, 1'b0);
      ld("lw_top", F3_W, DEPTH * 4 - 4, 32'h0BAD_F00D, 1'b0);
      ld("bad_f3", 3'b011, 32'h10, 32'h0, 1'b1);
      access("wr_dir_bad", 1'b0, 1'b1, 1'b1, F3_W, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 1, c1, t1);
      st("sw_misal", F3_W, 32'h12, 32'h5555_5555, 1'b1);
      st("sbu_store", F3_BU, 32'h10, 32'h0, 1'b1);
      ld("lw_10_final", F3_W, 32'h10, 32'h1234_80EF, 1'b0);

      st("sw_led", F3_W, IO_BASE, 32'h0000_01A5, 1'b0);
      check("led_val", {24'h0, led}, 32'h0000_00A5);
      ld("lw_led", F3_W, IO_BASE, 32'h0000_00A5, 1'b0);
      ld("lb_led_bad", F3_B, IO_BASE, 32'h0, 1'b1);
      access("lw_cnt1", 1'b1, 1'b0, 1'b1, F3_W, IO_BASE + 4, 32'h0, 32'h0, 1'b0, 1'b0, 2, c1, t1);
      repeat (10) @(negedge CLK);
      access("lw_cnt2", 1'b1, 1'b0, 1'b1, F3_W, IO_BASE + 4, 32'h0, 32'h0, 1'b0, 1'b0, 2, c2, t2);
      check("cnt_delta", c2 - c1, 32'(t2 - t1));
      st("sw_cnt_ro", F3_W, IO_BASE + 4, 32'h0, 1'b1);
      st("sw_io_gap", F3_W, IO_BASE + 8, 32'h0, 1'b1);

      // Reset lands on the edge that would end the RD cycle; the request stays held.
      @(negedge CLK);
      MemRead = 1'b1; MemWrite = 1'b0; d_rw = 1'b1; funct3 = F3_W; daddr = 32'h10;
      @(negedge CLK);
      RESET_N = 1'b0;
      @(negedge CLK);
      check("midrst_ready", {31'b0, d_ready}, 32'h0);
      check("midrst_ddata_r", ddata_r, 32'h0);
      check("midrst_led", {24'h0, led}, 32'h0);
      RESET_N = 1'b1;
      e.name = "lw_after_rst"; e.data = 32'h1234_80EF; e.chk = 1'b1; e.err = 1'b0;
      e.lat = 2; e.t0 = cyc;
      sb.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLK);
         seen = d_ready;
      end
      MemRead = 1'b0;
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL lw_after_rst_timeout: no d_ready within 10 cycles, required latency 2");
      end

      repeat (3) @(negedge CLK);
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
